sha256_msg_padder: RTL and testbench
====================================

// Module: sha256_msg_padder
// PURPOSE
// Parametrised SHA-256 preprocessing stage: accepts message words via valid/ready, applies
// FIPS 180-4 padding (0x1 bit, zeros, 64-bit big-endian length) and emits 512-bit chunks via
// valid/ready with backpressure. Sits between the message source and the chunk/compression
// stage. Adds a double-hash mode that pads a 256-bit digest into one chunk for the second pass.
// PARAMETERS
// LEN_W   15  width of msg_len (message length in bits); max message 2^LEN_W-1 bits
// CNT_W   LEN_W-8  width of chunk_idx (holds max chunk count floor((len+64)/512)+1)
// PORTS
// clock        in   1    single clock, all state on rising edge
// reset        in   1    asynchronous, active-low; clears all state
// start        in   1    pulse in IDLE: latch msg_len, begin message (ignored when busy)
// msg_len      in   LEN_W message length in bits, sampled on start
// dbl_start    in   1    pulse in IDLE: pad digest_in as 256-bit message (start has priority)
// digest_in    in   256  digest for double-hash pass, sampled on dbl_start, MSB = first bit
// in_data      in   32   message word, MSB = earliest bit; bits past msg_len ignored
// in_valid     in   1    in_data valid
// in_ready     out  1    padder accepts word this cycle
// chunk        out  512  padded chunk, word0 in [511:480]
// chunk_valid  out  1    chunk stable and valid until accepted
// chunk_ready  in   1    downstream accepts chunk
// chunk_last   out  1    chunk carries the length field (final chunk)
// chunk_idx    out  CNT_W index of current chunk, 0-based
// busy         out  1    high from start/dbl_start accept until last chunk accepted
// BEHAVIOUR
// - Reset values: in_ready=0, chunk=0, chunk_valid=0, chunk_last=0, chunk_idx=0, busy=0.
// - FSM: IDLE -> LOAD (start, msg_len>0) | PAD (start, msg_len=0) | PAD (dbl_start);
//   LOAD -> PAD when all ceil(len/32) words consumed; LOAD/PAD -> EMIT when word 15 written;
//   EMIT -> LOAD/PAD on handshake if more chunks, else IDLE (busy drops same edge).
// - LOAD: in_ready=1; one word written per in_valid&in_ready; gaps in in_valid tolerated.
// - Partial last word: keep top (len mod 32) bits, set next bit to 1, zero rest.
//   len mod 32 = 0: the pad word 0x80000000 is generated in PAD.
// - PAD: one word per cycle; zeros, then words 14/15 of final chunk = len[63:32], len[31:0]
//   (upper bits zero-extended from LEN_W). Pad-1 bit written exactly once per message.
// - Chunk count = floor((len+64)/512)+1; len mod 512 in 448..511 -> extra all-pad chunk.
// - Latency: chunk_valid rises the cycle after word 15 is written; chunk held stable while
//   chunk_valid & !chunk_ready; no LOAD/PAD progress during EMIT (single buffer).
// - Double mode: chunk = digest_in, 0x80000000, zeros, word15 = 0x00000100; chunk_last=1.
// - start/dbl_start while busy: ignored, no state change. Both in IDLE: start wins.
// - reset asserted mid-operation: immediate return to IDLE, partial chunk discarded.
// STRUCTURE
// - sha256_pkg: WORD_W=32, CHUNK_W=512, PAD_WORD=32'h8000_0000, state enum
//   (IDLE, LOAD, PAD, EMIT), IV constants H0..H7 shared with compression stage.
// - Sub-module sha256_pad_word: combinational word builder (data, bits-remaining, pad flag,
//   word position, final-chunk flag, length) -> 32-bit padded word.
// - Top: FSM, 4-bit word pointer, bits-remaining counter, chunk counter, 512-bit buffer.
// TESTING
// - len=0, start -> one chunk: word0 0x80000000, words1-15 0, chunk_last=1, chunk_idx=0.
// - len=24, in_data 0x61626300 ("abc") -> word0 0x61626380, word15 0x00000018, 1 chunk.
// - len=448, 14 words of 0xFFFFFFFF -> 2 chunks: #0 word14 0x80000000, word15 0;
//   #1 words0-13 0, word15 0x000001C0, chunk_last only on #1, chunk_idx 0 then 1.
// - len=512 with in_valid toggling every other cycle, chunk_ready low 5 cycles on each chunk
//   -> chunk stable while stalled, 2 chunks, #1 word0 0x80000000, word15 0x00000200.
// - dbl_start, digest_in=0x6a09e667..5be0cd19 -> words0-7 = digest, word8 0x80000000,
//   word15 0x00000100; start pulsed while busy -> ignored.
// - reset low mid-LOAD (after 7 words) -> all outputs reset values next sample; new len=24
//   message afterwards produces correct single chunk.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the padder state encoding.
package sha256_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned CHUNK_W  = 512;
  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  // Initial hash values, shared with the compression stage.
  localparam logic [31:0] H0 = 32'h6a09_e667;
  localparam logic [31:0] H1 = 32'hbb67_ae85;
  localparam logic [31:0] H2 = 32'h3c6e_f372;
  localparam logic [31:0] H3 = 32'ha54f_f53a;
  localparam logic [31:0] H4 = 32'h510e_527f;
  localparam logic [31:0] H5 = 32'h9b05_688c;
  localparam logic [31:0] H6 = 32'h1f83_d9ab;
  localparam logic [31:0] H7 = 32'h5be0_cd19;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PAD,
    EMIT
  } state_t;

endpackage

// File: rtl/sha256_pad_word.sv
// Combinational builder for one padded 32-bit chunk word.
module sha256_pad_word
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 15
) (
  input  logic [WORD_W-1:0] data,
  input  logic [LEN_W-1:0]  bits_rem,
  input  logic              pad_done,
  input  logic [3:0]        word_pos,
  input  logic              final_chunk,
  input  logic [LEN_W-1:0]  msg_len,
  output logic [WORD_W-1:0] word,
  output logic              pad_bit
);

  logic [63:0] len64;
  logic [4:0]  part;

  assign len64 = 64'(msg_len);
  assign part  = bits_rem[4:0];

  // Select full data, partial data plus pad bit, length field, pad word or zero.
  always_comb begin
    word    = '0;
    pad_bit = 1'b0;
    if (bits_rem > LEN_W'(31)) begin
      word = data;
    end else if (bits_rem != '0) begin
      word    = (data & ~(32'hFFFF_FFFF >> part)) | (PAD_WORD >> part);
      pad_bit = 1'b1;
    end else if (final_chunk && (word_pos == 4'd14)) begin
      word = len64[63:32];
    end else if (final_chunk && (word_pos == 4'd15)) begin
      word = len64[31:0];
    end else if (!pad_done) begin
      word    = PAD_WORD;
      pad_bit = 1'b1;
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams 32-bit words in, emits padded 512-bit chunks.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 15,
  parameter int unsigned CNT_W = LEN_W - 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   msg_len,
  input  logic               dbl_start,
  input  logic [255:0]       digest_in,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [CHUNK_W-1:0] chunk,
  output logic               chunk_valid,
  input  logic               chunk_ready,
  output logic               chunk_last,
  output logic [CNT_W-1:0]   chunk_idx,
  output logic               busy
);

  state_t state, state_nxt;

  logic [3:0]              wptr;
  logic [LEN_W-1:0]        bits_rem;
  logic [LEN_W-1:0]        len_q;
  logic                    pad_done;
  logic [CNT_W-1:0]        idx_q;
  logic [CNT_W-1:0]        last_idx;
  logic [0:15][WORD_W-1:0] buf_w;
  logic [LEN_W:0]          cnt_span;

  logic              final_chunk;
  logic              last_word;
  logic [WORD_W-1:0] pad_word;
  logic              pad_bit;
  logic              wr_en;
  logic              load_go;
  logic              dbl_go;
  logic              emit_ack;

  assign cnt_span    = {1'b0, msg_len} + (LEN_W + 1)'(64);
  assign final_chunk = (idx_q == last_idx);
  assign last_word   = (bits_rem <= LEN_W'(32));
  assign chunk       = buf_w;
  assign chunk_idx   = idx_q;

  sha256_pad_word #(
    .LEN_W (LEN_W)
  ) u_pad_word (
    .data        (in_data),
    .bits_rem    (bits_rem),
    .pad_done    (pad_done),
    .word_pos    (wptr),
    .final_chunk (final_chunk),
    .msg_len     (len_q),
    .word        (pad_word),
    .pad_bit     (pad_bit)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    load_go     = 1'b0;
    dbl_go      = 1'b0;
    emit_ack    = 1'b0;
    in_ready    = 1'b0;
    chunk_valid = 1'b0;
    chunk_last  = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load_go   = 1'b1;
          state_nxt = (msg_len != '0) ? LOAD : PAD;
        end else if (dbl_start) begin
          dbl_go    = 1'b1;
          state_nxt = PAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (wptr == 4'd15)  state_nxt = EMIT;
          else if (last_word) state_nxt = PAD;
        end
      end
      PAD: begin
        wr_en = 1'b1;
        if (wptr == 4'd15) state_nxt = EMIT;
      end
      EMIT: begin
        chunk_valid = 1'b1;
        chunk_last  = final_chunk;
        if (chunk_ready) begin
          emit_ack = 1'b1;
          if (final_chunk)          state_nxt = IDLE;
          else if (bits_rem != '0)  state_nxt = LOAD;
          else                      state_nxt = PAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: message bookkeeping and the chunk buffer.
  // Double-hash preloads the digest into words 0-7 and enters PAD at word 8,
  // so it reuses the normal padding path as a 256-bit message.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      bits_rem <= '0;
      len_q    <= '0;
      pad_done <= 1'b0;
      idx_q    <= '0;
      last_idx <= '0;
      buf_w    <= '0;
    end else if (load_go) begin
      wptr     <= '0;
      bits_rem <= msg_len;
      len_q    <= msg_len;
      pad_done <= 1'b0;
      idx_q    <= '0;
      last_idx <= CNT_W'(cnt_span >> 9);
    end else if (dbl_go) begin
      wptr        <= 4'd8;
      bits_rem    <= '0;
      len_q       <= LEN_W'(256);
      pad_done    <= 1'b0;
      idx_q       <= '0;
      last_idx    <= '0;
      buf_w[0:7]  <= digest_in;
    end else begin
      if (wr_en) begin
        buf_w[wptr] <= pad_word;
        wptr        <= wptr + 4'd1;
        bits_rem    <= (bits_rem > LEN_W'(31)) ? bits_rem - LEN_W'(32) : '0;
        if (pad_bit) pad_done <= 1'b1;
      end
      if (emit_ack && !final_chunk) idx_q <= idx_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: directed table, reset corner and randomized messages
// checked against a bit-level FIPS 180-4 padding model.
module tb_sha256_msg_padder;

  localparam int unsigned LEN_W = 15;
  localparam int unsigned CNT_W = LEN_W - 8;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [LEN_W-1:0]   msg_len;
  logic               dbl_start;
  logic [255:0]       digest_in;
  logic [31:0]        in_data;
  logic               in_valid;
  logic               in_ready;
  logic [511:0]       chunk;
  logic               chunk_valid;
  logic               chunk_ready;
  logic               chunk_last;
  logic [CNT_W-1:0]   chunk_idx;
  logic               busy;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]  msg_words[$];
  logic [511:0] exp_q[$];

  typedef struct {
    int          len;
    bit          dbl;
    bit          both;
    logic [31:0] fill;
    int          gap;
    int          stall;
    bit          poke;
    int          exp_n;
    logic [31:0] exp_w0;
    logic [31:0] exp_w15;
  } vec_t;

  sha256_msg_padder #(
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .msg_len     (msg_len),
    .dbl_start   (dbl_start),
    .digest_in   (digest_in),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .chunk       (chunk),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .chunk_last  (chunk_last),
    .chunk_idx   (chunk_idx),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_words(input int len, input logic [31:0] fill, input bit rnd);
    msg_words.delete();
    for (int i = 0; i < (len + 31) / 32; i++)
      msg_words.push_back(rnd ? 32'($urandom) : fill);
  endtask

  task automatic set_digest_words(input logic [255:0] dg);
    msg_words.delete();
    for (int i = 0; i < 8; i++) msg_words.push_back(dg[255 - 32*i -: 32]);
  endtask

  // Message bits, a single 1, zeros up to 448 mod 512, then the 64-bit length.
  task automatic build_model(input int len);
    bit          pm[$];
    logic [63:0] l64;
    logic [511:0] v;
    l64 = 64'(len);
    exp_q.delete();
    for (int i = 0; i < len; i++) pm.push_back(msg_words[i/32][31 - (i % 32)]);
    pm.push_back(1'b1);
    while ((pm.size() % 512) != 448) pm.push_back(1'b0);
    for (int i = 63; i >= 0; i--) pm.push_back(l64[i]);
    for (int c = 0; c < pm.size() / 512; c++) begin
      for (int b = 0; b < 512; b++) v[511 - b] = pm[c*512 + b];
      exp_q.push_back(v);
    end
  endtask

  task automatic run_msg(input string nm, input int len, input bit dbl, input bit both,
                         input logic [255:0] dg, input int gap, input int stall, input bit poke,
                         output int n_seen, output logic [31:0] w0, output logic [31:0] w15);
    int           wi;
    int           ci;
    int           cyc;
    int           scnt;
    int           nwords;
    bit           acc;
    bit           holding;
    logic [511:0] held;
    wi = 0; ci = 0; cyc = 0; scnt = 0; holding = 0; held = '0;
    n_seen = 0; w0 = '0; w15 = '0;
    nwords = dbl ? 0 : msg_words.size();
    digest_in = dg;
    if (dbl) begin
      dbl_start = 1'b1;
    end else begin
      start     = 1'b1;
      msg_len   = LEN_W'(len);
      dbl_start = both;
    end
    @(posedge clock); #1;
    start = 1'b0; dbl_start = 1'b0;
    chk({nm, " busy after start"}, 512'(busy), 512'(1));
    while (ci < exp_q.size() && cyc < 4000) begin
      start = 1'b0;
      if (poke && cyc == 3) begin
        start   = 1'b1;
        msg_len = LEN_W'(100);
      end
      in_valid = 1'b0;
      in_data  = $urandom;
      if (in_ready && wi < nwords) begin
        case (gap)
          0:       in_valid = 1'b1;
          1:       in_valid = ((cyc % 2) == 0);
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        if (in_valid) in_data = msg_words[wi];
      end
      chunk_ready = 1'b0;
      if (chunk_valid) begin
        if (!holding) begin
          holding = 1'b1;
          held    = chunk;
          scnt    = 0;
        end else begin
          chk({nm, " chunk stable while stalled"}, chunk, held);
        end
        case (stall)
          0:       chunk_ready = 1'b1;
          1:       chunk_ready = (scnt >= 5);
          default: chunk_ready = 1'($urandom_range(0, 1));
        endcase
        scnt++;
        if (chunk_ready) begin
          chk($sformatf("%s chunk%0d data", nm, ci), chunk, exp_q[ci]);
          chk($sformatf("%s chunk%0d last", nm, ci), 512'(chunk_last), 512'(ci == exp_q.size() - 1));
          chk($sformatf("%s chunk%0d idx", nm, ci), 512'(chunk_idx), 512'(ci));
          if (ci == 0) w0 = chunk[511:480];
          w15 = chunk[31:0];
          ci++;
          n_seen  = ci;
          holding = 1'b0;
        end
      end
      acc = in_valid && in_ready;
      @(posedge clock); #1;
      if (acc) wi++;
      cyc++;
    end
    in_valid = 1'b0; chunk_ready = 1'b0; start = 1'b0;
    if (ci < exp_q.size()) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: got %0d chunks, expected %0d", nm, ci, exp_q.size());
    end
    chk({nm, " busy after last chunk"}, 512'(busy), 512'(0));
    chk({nm, " words consumed"}, 512'(wi), 512'(nwords));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " in_ready"}, 512'(in_ready), 512'(0));
    chk({nm, " chunk"}, chunk, 512'(0));
    chk({nm, " chunk_valid"}, 512'(chunk_valid), 512'(0));
    chk({nm, " chunk_last"}, 512'(chunk_last), 512'(0));
    chk({nm, " chunk_idx"}, 512'(chunk_idx), 512'(0));
    chk({nm, " busy"}, 512'(busy), 512'(0));
  endtask

  initial begin
    vec_t         tbl[8];
    int           n;
    int           bl[8];
    int           len;
    logic [31:0]  w0;
    logic [31:0]  w15;
    logic [255:0] dg;

    reset = 1'b0; start = 1'b0; dbl_start = 1'b0; in_valid = 1'b0; in_data = '0;
    chunk_ready = 1'b0; msg_len = '0; digest_in = '0;
    dg = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    tbl[0] = '{len:0,   dbl:0, both:0, fill:32'h0,        gap:0, stall:0, poke:0, exp_n:1, exp_w0:32'h8000_0000, exp_w15:32'h0000_0000};
    tbl[1] = '{len:24,  dbl:0, both:0, fill:32'h6162_6300, gap:0, stall:0, poke:0, exp_n:1, exp_w0:32'h6162_6380, exp_w15:32'h0000_0018};
    tbl[2] = '{len:448, dbl:0, both:0, fill:32'hFFFF_FFFF, gap:0, stall:0, poke:0, exp_n:2, exp_w0:32'hFFFF_FFFF, exp_w15:32'h0000_01C0};
    tbl[3] = '{len:512, dbl:0, both:0, fill:32'h1234_5678, gap:1, stall:1, poke:0, exp_n:2, exp_w0:32'h1234_5678, exp_w15:32'h0000_0200};
    tbl[4] = '{len:256, dbl:1, both:0, fill:32'h0,        gap:0, stall:0, poke:1, exp_n:1, exp_w0:32'h6a09_e667, exp_w15:32'h0000_0100};
    tbl[5] = '{len:24,  dbl:0, both:1, fill:32'h6162_6300, gap:0, stall:0, poke:0, exp_n:1, exp_w0:32'h6162_6380, exp_w15:32'h0000_0018};
    tbl[6] = '{len:447, dbl:0, both:0, fill:32'hFFFF_FFFF, gap:2, stall:2, poke:0, exp_n:1, exp_w0:32'hFFFF_FFFF, exp_w15:32'h0000_01BF};
    tbl[7] = '{len:32,  dbl:0, both:0, fill:32'hA5A5_A5A5, gap:0, stall:1, poke:0, exp_n:1, exp_w0:32'hA5A5_A5A5, exp_w15:32'h0000_0020};

    #2;
    chk_reset_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].dbl) set_digest_words(dg);
      else            set_words(tbl[i].len, tbl[i].fill, 1'b0);
      build_model(tbl[i].len);
      run_msg($sformatf("tbl%0d", i), tbl[i].len, tbl[i].dbl, tbl[i].both, dg,
              tbl[i].gap, tbl[i].stall, tbl[i].poke, n, w0, w15);
      chk($sformatf("tbl%0d chunk count", i), 512'(n), 512'(tbl[i].exp_n));
      chk($sformatf("tbl%0d first word0", i), 512'(w0), 512'(tbl[i].exp_w0));
      chk($sformatf("tbl%0d last word15", i), 512'(w15), 512'(tbl[i].exp_w15));
      if (i == 2) chk("tbl2 chunk0 word14", 512'(exp_q[0][63:32]), 512'(32'h8000_0000));
    end

    // Reset in the middle of loading a 448-bit message.
    msg_len = LEN_W'(448);
    start   = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    repeat (7) @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("midload busy before reset", 512'(busy), 512'(1));
    reset = 1'b0;
    #1;
    chk_reset_outputs("midload reset");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    set_words(24, 32'h6162_6300, 1'b0);
    build_model(24);
    run_msg("after reset", 24, 1'b0, 1'b0, dg, 0, 0, 1'b0, n, w0, w15);
    chk("after reset chunk count", 512'(n), 512'(1));
    chk("after reset word0", 512'(w0), 512'(32'h6162_6380));
    chk("after reset word15", 512'(w15), 512'(32'h0000_0018));

    // Randomized messages: boundary lengths first, then free lengths.
    bl = '{1, 31, 449, 479, 480, 511, 513, 960};
    for (int i = 0; i < 16; i++) begin
      len = (i < 8) ? bl[i] : int'($urandom_range(0, 1800));
      set_words(len, 32'h0, 1'b1);
      build_model(len);
      run_msg($sformatf("rnd%0d len%0d", i, len), len, 1'b0, 1'b0, dg,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, n, w0, w15);
    end

    dg = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    set_digest_words(dg);
    build_model(256);
    run_msg("rnd dbl", 256, 1'b1, 1'b0, dg, 0, 2, 1'b1, n, w0, w15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
